// File: rtl/mtm_alu_deserializer_if.sv
// Packet bus between the serial front-end and the ALU core: serial input in,
// assembled operands/opcode and one-cycle valid/err pulses out.
interface mtm_alu_deserializer_if;
  logic        sin;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        valid;
  logic        err;
  logic [2:0]  err_flags;

  // master: the deserializer, which drives the decoded packet
  modport master (
    input  sin,
    output a, b, op, valid, err, err_flags
  );

  // slave: the serial source / ALU core side
  modport slave (
    output sin,
    input  a, b, op, valid, err, err_flags
  );
endinterface

// File: rtl/mtm_alu_deserializer.sv
// Serial receive front-end: 11-bit frames -> {B, A, OP} packet with framing, count, CRC4 and opcode checks.
// Define MTM_DESER_CRC_CHECK_EN to enable the CRC4 check; otherwise the CRC field is ignored.
module mtm_alu_deserializer (
  input  logic                          clk,
  input  logic                          rst_n,
  mtm_alu_deserializer_if.master        bus
);
  typedef enum logic [1:0] {S_IDLE, S_TYPE, S_PAYLOAD, S_STOP} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic        is_cmd_reg, is_cmd_next;
  logic [7:0]  payload_reg, payload_next;
  logic [63:0] sr_reg, sr_next;
  logic [3:0]  dcnt_reg, dcnt_next;
  logic        bad_reg, bad_next;
  logic [31:0] a_reg, a_next;
  logic [31:0] b_reg, b_next;
  logic [2:0]  op_reg, op_next;
  logic        valid_reg, valid_next;
  logic        err_reg, err_next;
  logic [2:0]  flags_reg, flags_next;

  logic [2:0]  cmd_op;
  logic        op_legal;
  logic        crc_ok;

  assign cmd_op   = payload_reg[6:4];
  // Legal opcodes are 000/001/100/101, i.e. exactly those with op[1] clear.
  assign op_legal = (cmd_op[1] == 1'b0);

`ifdef MTM_DESER_CRC_CHECK_EN
  function automatic logic [3:0] crc4(input logic [67:0] d);
    logic [3:0] c;
    logic       fb;
    c = 4'd0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  assign crc_ok = (crc4({sr_reg, 1'b1, cmd_op}) == payload_reg[3:0]);
`else
  assign crc_ok = 1'b1;
`endif

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    is_cmd_next  = is_cmd_reg;
    payload_next = payload_reg;
    sr_next      = sr_reg;
    dcnt_next    = dcnt_reg;
    bad_next     = bad_reg;
    a_next       = a_reg;
    b_next       = b_reg;
    op_next      = op_reg;
    valid_next   = 1'b0;
    err_next     = 1'b0;
    flags_next   = 3'b000;

    case (state_reg)
      S_IDLE: begin
        if (!bus.sin) state_next = S_TYPE;
      end
      S_TYPE: begin
        is_cmd_next  = bus.sin;
        bit_cnt_next = 3'd0;
        state_next   = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        payload_next = {payload_reg[6:0], bus.sin};
        bit_cnt_next = bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) state_next = S_STOP;
      end
      S_STOP: begin
        state_next = S_IDLE;
        if (is_cmd_reg) begin
          // A broken stop bit on the CMD frame itself counts as a data error.
          dcnt_next = 4'd0;
          bad_next  = 1'b0;
          if (bad_reg || !bus.sin || (dcnt_reg != 4'd8)) begin
            err_next   = 1'b1;
            flags_next = 3'b100;
          end else if (!crc_ok) begin
            err_next   = 1'b1;
            flags_next = 3'b010;
          end else if (!op_legal) begin
            err_next   = 1'b1;
            flags_next = 3'b001;
          end else begin
            valid_next = 1'b1;
            b_next     = sr_reg[63:32];
            a_next     = sr_reg[31:0];
            op_next    = cmd_op;
          end
        end else if (bus.sin) begin
          sr_next = {sr_reg[55:0], payload_reg};
          if (dcnt_reg != 4'd9) dcnt_next = dcnt_reg + 4'd1;
        end else begin
          bad_next = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      bit_cnt_reg <= 3'd0;
      is_cmd_reg  <= 1'b0;
      payload_reg <= 8'd0;
      sr_reg      <= 64'd0;
      dcnt_reg    <= 4'd0;
      bad_reg     <= 1'b0;
      a_reg       <= 32'd0;
      b_reg       <= 32'd0;
      op_reg      <= 3'd0;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
      flags_reg   <= 3'd0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      is_cmd_reg  <= is_cmd_next;
      payload_reg <= payload_next;
      sr_reg      <= sr_next;
      dcnt_reg    <= dcnt_next;
      bad_reg     <= bad_next;
      a_reg       <= a_next;
      b_reg       <= b_next;
      op_reg      <= op_next;
      valid_reg   <= valid_next;
      err_reg     <= err_next;
      flags_reg   <= flags_next;
    end
  end

  assign bus.a         = a_reg;
  assign bus.b         = b_reg;
  assign bus.op        = op_reg;
  assign bus.valid     = valid_reg;
  assign bus.err       = err_reg;
  assign bus.err_flags = flags_reg;
endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// Randomized self-checking bench for mtm_alu_deserializer against a packet-level model.
`timescale 1ns/1ps
module tb_mtm_alu_deserializer;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  mtm_alu_deserializer_if bus ();
  mtm_alu_deserializer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit       is_cmd;
    logic [7:0] payload;
    bit       stop_ok;
  } frame_t;

  typedef struct {
    logic        v;
    logic        e;
    logic [2:0]  flags;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    int          cyc;
  } ev_t;

  frame_t pkt_q[$];
  ev_t    ev_q[$];
  ev_t    last_ev;

  logic [63:0] m_sr;
  logic [31:0] m_a, m_b;
  logic [2:0]  m_op;
  int n_pass = 0, n_checks = 0;
  int start_cyc, stop_cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // CRC as remainder of polynomial long division of msg * x^4 by x^4+x+1.
  function automatic logic [3:0] crc_ref(input logic [67:0] d);
    logic [71:0] m;
    m = {d, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
    return m[3:0];
  endfunction

  function automatic logic [7:0] good_cmd(input logic [63:0] ops, input logic [2:0] op);
    return {1'b0, op, crc_ref({ops, 1'b1, op})};
  endfunction

  always @(negedge clk) begin
    ev_t ev;
    if (bus.valid || bus.err) begin
      ev.v = bus.valid; ev.e = bus.err; ev.flags = bus.err_flags;
      ev.a = bus.a; ev.b = bus.b; ev.op = bus.op; ev.cyc = cyc;
      ev_q.push_back(ev);
      check("excl", 64'(bus.valid & bus.err), 64'd0);
    end
    if (!bus.err) check("flags_idle", 64'(bus.err_flags), 64'd0);
  end

  task automatic send_bit(input logic v);
    @(posedge clk);
    #1;
    bus.sin = v;
  endtask

  task automatic send_frame(input frame_t f);
    send_bit(1'b0);
    send_bit(f.is_cmd);
    for (int i = 7; i >= 0; i--) send_bit(f.payload[i]);
    send_bit(f.stop_ok);
    stop_cyc = cyc;
  endtask

  task automatic build_pkt(input logic [63:0] ops, input int ndata, input logic [7:0] cmd, input int err_frame);
    frame_t f;
    pkt_q.delete();
    for (int i = 0; i < ndata; i++) begin
      f.is_cmd  = 1'b0;
      f.payload = (i < 8) ? ops[63 - 8*(i % 8) -: 8] : 8'h5A;
      f.stop_ok = (i != err_frame);
      pkt_q.push_back(f);
    end
    f.is_cmd  = 1'b1;
    f.payload = cmd;
    f.stop_ok = (ndata != err_frame);
    pkt_q.push_back(f);
  endtask

  task automatic run_pkt(input string tag, input int gap);
    bit         bad;
    int         n;
    logic       exp_v;
    logic [2:0] exp_f, cop;
    logic [3:0] ccrc;
    frame_t     cmd;
    bad = 0; n = 0; cmd = pkt_q[pkt_q.size()-1];
    foreach (pkt_q[i]) begin
      if (pkt_q[i].is_cmd) begin
        if (!pkt_q[i].stop_ok) bad = 1;
      end else if (pkt_q[i].stop_ok) begin
        m_sr = {m_sr[55:0], pkt_q[i].payload};
        n++;
      end else bad = 1;
    end
    cop  = cmd.payload[6:4];
    ccrc = cmd.payload[3:0];
    exp_v = 1'b0;
    exp_f = 3'b000;
    if (bad || n != 8) exp_f = 3'b100;
`ifdef MTM_DESER_CRC_CHECK_EN
    else if (ccrc != crc_ref({m_sr, 1'b1, cop})) exp_f = 3'b010;
`endif
    else if (!(cop inside {3'd0, 3'd1, 3'd4, 3'd5})) exp_f = 3'b001;
    else begin
      exp_v = 1'b1; m_b = m_sr[63:32]; m_a = m_sr[31:0]; m_op = cop;
    end

    ev_q.delete();
    foreach (pkt_q[i]) begin
      if (i > 0) repeat (gap) send_bit(1'b1);
      if (i == 0) start_cyc = cyc + 1 - 1;
      if (i == 0) begin
        @(posedge clk); #1; start_cyc = cyc; bus.sin = 1'b0;
        send_bit(pkt_q[i].is_cmd);
        for (int k = 7; k >= 0; k--) send_bit(pkt_q[i].payload[k]);
        send_bit(pkt_q[i].stop_ok);
        stop_cyc = cyc;
      end else send_frame(pkt_q[i]);
    end
    repeat (3) send_bit(1'b1);

    check({tag, ":n_ev"}, 64'(ev_q.size()), 64'd1);
    if (ev_q.size() > 0) begin
      last_ev = ev_q[0];
      check({tag, ":kind"}, 64'({last_ev.v, last_ev.e}), exp_v ? 64'd2 : 64'd1);
      check({tag, ":flags"}, 64'(last_ev.flags), 64'(exp_f));
      check({tag, ":a"}, 64'(last_ev.a), 64'(m_a));
      check({tag, ":b"}, 64'(last_ev.b), 64'(m_b));
      check({tag, ":op"}, 64'(last_ev.op), 64'(m_op));
      check({tag, ":lat"}, 64'(last_ev.cyc - stop_cyc), 64'd1);
    end
    $display("pkt %-12s frames=%0d good_data=%0d cmd=%02h expect=%s flags=%03b a=%08h b=%08h",
             tag, pkt_q.size(), n, cmd.payload, exp_v ? "valid" : "err", exp_f, m_a, m_b);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ":a"},     64'(bus.a), 64'd0);
    check({tag, ":b"},     64'(bus.b), 64'd0);
    check({tag, ":op"},    64'(bus.op), 64'd0);
    check({tag, ":valid"}, 64'(bus.valid), 64'd0);
    check({tag, ":err"},   64'(bus.err), 64'd0);
    check({tag, ":flags"}, 64'(bus.err_flags), 64'd0);
  endtask

  initial begin
    logic [63:0] ops;
    logic [2:0]  op;
    logic [7:0]  cmd;
    int          mode, nd, ef;

    rst_n = 1'b0;
    bus.sin = 1'b1;
    m_sr = '0; m_a = '0; m_b = '0; m_op = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    build_pkt(64'd0, 8, 8'h0B, -1);  run_pkt("zero_and", 1);
    build_pkt(64'd0, 8, 8'h0A, -1);  run_pkt("crc_bad", 1);
    build_pkt(64'd0, 7, 8'h0B, -1);  run_pkt("seven_data", 0);
    build_pkt(64'd0, 8, 8'h18, -1);  run_pkt("or_recover", 2);
    build_pkt(64'd0, 8, 8'h2D, -1);  run_pkt("op_bad", 0);
    build_pkt(64'd0, 8, 8'h0B, 2);   run_pkt("stop_err3", 1);
    ops = 64'h1234_5678_9ABC_DEF0;
    build_pkt(ops, 8, good_cmd(ops, 3'b001), 8); run_pkt("cmd_stop", 0);
    build_pkt(ops, 24, good_cmd(ops, 3'b000), -1); run_pkt("many_data", 0);

    ops = {32'd2, 32'd1};
    build_pkt(ops, 8, good_cmd(ops, 3'b100), -1); run_pkt("add_b2b", 0);
    check("lat99", 64'(last_ev.cyc - start_cyc), 64'd99);

    // Abandon DATA frame 5 mid-payload with a reset, then send a clean packet.
    ops = {$urandom, $urandom};
    build_pkt(ops, 8, good_cmd(ops, 3'b101), -1);
    ev_q.delete();
    for (int i = 0; i < 4; i++) send_frame(pkt_q[i]);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    @(posedge clk); #1; rst_n = 1'b0; bus.sin = 1'b1;
    @(posedge clk); #1; rst_n = 1'b1;
    m_sr = '0; m_a = '0; m_b = '0; m_op = '0;
    check_reset_outputs("midrst");
    check("midrst:no_ev", 64'(ev_q.size()), 64'd0);
    ops = {$urandom, $urandom};
    build_pkt(ops, 8, good_cmd(ops, 3'b101), -1); run_pkt("after_rst", 1);

    repeat (40) begin
      ops  = {$urandom, $urandom};
      op   = 3'($urandom);
      mode = $urandom_range(0, 9);
      nd   = 8;
      ef   = -1;
      cmd  = good_cmd(ops, op);
      if (mode == 6) cmd[3:0] = cmd[3:0] ^ 4'($urandom_range(1, 15));
      else if (mode == 7) nd = ($urandom_range(0, 1) == 1) ? $urandom_range(5, 7) : $urandom_range(9, 11);
      else if (mode == 8) ef = $urandom_range(0, 7);
      else if (mode == 9) ef = 8;
      build_pkt(ops, nd, cmd, ef);
      run_pkt("rand", $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mtm_alu_deserializer.md
# mtm_alu_deserializer

Serial receive front-end of the ALU: it sits directly upstream of the ALU core. It samples the single-wire input `sin` at one bit per `clk` and assembles 11-bit frames into a packet of operands A and B plus a command byte. It checks framing, data-frame count, CRC4 and opcode, then delivers either a one-cycle `valid` with operands or a one-cycle `err` with error flags.

## Interface
- Parameters: none; the frame format is fixed.
- `clk` in 1: clock; all logic on posedge.
- `rst_n` in 1: reset, synchronous, active-low.
- `sin` in 1: serial input; idles high.
- `a` out 32: operand A.
- `b` out 32: operand B.
- `op` out 3: opcode.
- `valid` out 1: one-cycle pulse; `a`/`b`/`op` are valid in that cycle and held until the next `valid`.
- `err` out 1: one-cycle pulse; packet rejected.
- `err_flags` out 3: `{ERR_DATA, ERR_CRC, ERR_OP}`; meaningful while `err`=1, otherwise 0.

## Operation
- Frame, 11 bits: start bit 0, type bit (0=DATA, 1=CMD), 8 payload bits MSB first, stop bit 1.
- Packet: 8 DATA frames carrying B[31:24], B[23:16], B[15:8], B[7:0], then A[31:24] down to A[7:0]; then 1 CMD frame with payload `{1'b0, OP[2:0], CRC[3:0]}`.
- FSM states:
  - IDLE: `sin`=0 → TYPE.
  - TYPE: latch type bit → PAYLOAD.
  - PAYLOAD: 8 cycles, 3-bit counter → STOP.
  - STOP → IDLE.
- In STOP, `sin`=1 commits the frame:
  - DATA frame: shift the byte into the 64-bit operand register and increment `dcnt`, which saturates at 9.
  - CMD frame: evaluate the packet.
- In STOP, `sin`=0 is a framing error: discard the byte and set the sticky `bad` flag.
- CMD evaluation, first match wins:
  - `bad` or `dcnt`≠8 → ERR_DATA only (3'b100).
  - CRC mismatch → ERR_CRC (3'b010).
  - OP ∉ {000 AND, 001 OR, 100 ADD, 101 SUB} → ERR_OP (3'b001).
  - Otherwise → `valid`.
- A CMD frame with a framing error is treated as a CMD with `bad` set, so it reports ERR_DATA.
- CRC4:
  - Polynomial x^4+x+1, initial value 0, no reflection, no final XOR.
  - Computed over the 68 bits `{B, A, 1'b1, OP}`, MSB first.
- After any CMD frame, good or bad: `dcnt`=0, `bad`=0, operand shift register not cleared.
- On `err`, `a`/`b`/`op` keep their previous values.

## Timing
- Reset values: `a`=0, `b`=0, `op`=0, `valid`=0, `err`=0, `err_flags`=0; FSM in IDLE, `dcnt`=0, `bad`=0.
- Latency: `valid`/`err` assert in the cycle after the clock edge that samples the CMD stop bit. Both are registered and high for exactly 1 cycle.
- `valid` and `err` are never high in the same cycle.
- Back-to-back frames: a start bit sampled in the cycle immediately after STOP is accepted, so the minimum frame period is 11 cycles.
- Idle gaps of any length are allowed between frames and between packets.
- `sin`=0 while in IDLE is always a start bit. There is no glitch filtering and no mid-bit sampling.
- `rst_n`=0 mid-frame: the frame is abandoned, the FSM returns to IDLE, counters and flags clear, and no pulse is emitted.

## Configuration
- Macro `MTM_DESER_CRC_CHECK_EN`:
  - Defined: the CRC4 check is active as above.
  - Undefined: the CRC field is ignored and ERR_CRC is never set. The ERR_DATA and ERR_OP checks are unchanged, and so is the port list.

## Test plan
- A=0, B=0 (8 DATA frames of 0x00), then CMD 0x0B (AND, CRC 4'hB) → `valid` one cycle after the CMD stop bit; `a`=0, `b`=0, `op`=3'b000.
- Same packet with CMD 0x0A:
  - Macro defined → `err`=1, `err_flags`=3'b010, `a`/`b`/`op` unchanged.
  - Macro undefined → `valid`=1.
- Only 7 DATA frames, then CMD 0x0B → `err_flags`=3'b100.
- Then a correct 8-DATA packet with CMD 0x18 (OR, CRC 4'h8) → `valid`, `op`=3'b001; the counter has recovered.
- 8 zero DATA frames, then CMD 0x2D (OP=010, CRC 4'hD) → `err_flags`=3'b001.
- Stop bit forced to 0 on DATA frame 3, remaining frames correct, CMD 0x0B → `err_flags`=3'b100.
- Separately: `rst_n` pulsed low in PAYLOAD of DATA frame 5, then a full correct packet → a single `valid` with the new operands.
- B=0x00000002, A=0x00000001, ADD, correct CRC from the bench model, sent with 0 idle cycles between frames → `valid`, `b`=2, `a`=1, `op`=3'b100, exactly 99 cycles after the first start bit.
